frame_render_scheduler: RTL and testbench

//  Sequences one frame of the pixel renderer in the user project area. On start, walks
//  the raster (x fastest) and issues pixel requests to a pipelined shader core. It buffers
//  the in-order RGB results and streams them to the output path.
//  It also drives the 8-bit progress code on mprj_io[7:0], which the DV bench tracks
//  (01..0A, FF, 00).

---
 rtl/frame_render_scheduler.sv | 159 +++++++++++++++
 tb/tb_frame_render_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_render_scheduler.sv
// Frame render scheduler: walks the raster issuing pixel requests to a pipelined shader,
// buffers in-order results in a small FIFO and streams them out with a progress code.
module frame_render_scheduler #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int MAX_OUT   = 4,
  parameter int DONE_HOLD = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start,
  output logic                       busy,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [$clog2(IMG_W)-1:0]   req_x,
  output logic [$clog2(IMG_H)-1:0]   req_y,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  input  logic [23:0]                rsp_rgb,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [23:0]                pix_data,
  output logic                       pix_last,
  output logic [7:0]                 status
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int CW  = XW + YW + 1;
  localparam int N   = IMG_W * IMG_H;
  localparam int GSH = XW + $clog2(IMG_H / 8);
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int FW  = $clog2(MAX_OUT + 1);
  localparam int HW  = $clog2(DONE_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_FLUSH2,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   emitted_q, emitted_d;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   row_grp;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [23:0]     mem_q [MAX_OUT];
  logic            run;
  logic            req_fire;
  logic            rsp_fire;
  logic            pix_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign run       = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign inflight  = issued_q - emitted_q;
  assign req_valid = run && (issued_q < CW'(N)) && (inflight < CW'(MAX_OUT));
  assign req_x     = issued_q[XW-1:0];
  assign req_y     = issued_q[XW+YW-1:XW];
  assign rsp_ready = run;
  assign pix_valid = (cnt_q != '0);
  assign pix_data  = mem_q[rd_q];
  assign pix_last  = pix_valid && (emitted_q == CW'(N - 1));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign pix_fire  = pix_valid && pix_ready;
  assign row_grp   = emitted_q >> GSH;

  // Progress code: RUN counts completed eighths of the frame; FLUSH spans two cycles (09, 0A).
  always_comb begin
    status = 8'h00;
    unique case (state_q)
      S_IDLE:   status = 8'h00;
      S_RUN:    status = 8'h01 + 8'(row_grp);
      S_FLUSH:  status = 8'h09;
      S_FLUSH2: status = 8'h0A;
      S_DONE:   status = 8'hFF;
      default:  status = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    emitted_d = emitted_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;

    if (rsp_fire) wr_d = ptr_inc(wr_q);
    if (pix_fire) rd_d = ptr_inc(rd_q);
    unique case ({rsp_fire, pix_fire})
      2'b10:   cnt_d = cnt_q + FW'(1);
      2'b01:   cnt_d = cnt_q - FW'(1);
      default: cnt_d = cnt_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          issued_d  = '0;
          emitted_d = '0;
        end
      end
      S_RUN: begin
        if (req_fire) issued_d  = issued_q + CW'(1);
        if (pix_fire) emitted_d = emitted_q + CW'(1);
        if (pix_fire && pix_last) state_d = S_FLUSH;
      end
      S_FLUSH:  state_d = S_FLUSH2;
      S_FLUSH2: begin
        state_d = S_DONE;
        hold_d  = '0;
      end
      S_DONE: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(DONE_HOLD - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      issued_q  <= '0;
      emitted_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      emitted_q <= emitted_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge wb_clk_i) begin
    if (rsp_fire) mem_q[wr_q] <= rsp_rgb;
  end

endmodule

// File: tb/tb_frame_render_scheduler.sv
// Bench for frame_render_scheduler: shader model with 3-cycle latency, raster scoreboard,
// table of frame scenarios plus hand sequences for reset and guard cases.
module tb_frame_render_scheduler;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int N  = W * H;
  localparam int MO = 4;
  localparam int DH = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start;
  logic        busy;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_x;
  logic [5:0]  req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [23:0] rsp_rgb;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_last;
  logic [7:0]  status;

  frame_render_scheduler #(.IMG_W(W), .IMG_H(H), .MAX_OUT(MO), .DONE_HOLD(DH)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .busy     (busy),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rgb  (rsp_rgb),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .pix_last (pix_last),
    .status   (status)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Shader model: fixed 3-stage pipeline echoing {x, y, x^y}.
  logic [2:0]  sh_v;
  logic [23:0] sh_d [3];
  logic        inj_v;
  logic [23:0] inj_rgb;

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sh_v <= '0;
    end else begin
      sh_v     <= {sh_v[1:0], req_valid && req_ready};
      sh_d[0]  <= {8'(req_x), 8'(req_y), 8'(req_x ^ req_y)};
      sh_d[1]  <= sh_d[0];
      sh_d[2]  <= sh_d[1];
    end
  end

  assign rsp_valid = sh_v[2] | inj_v;
  assign rsp_rgb   = inj_v ? inj_rgb : sh_d[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard and knobs shared by monitor, driver and test sequence.
  logic [24:0] sbq [$];
  int          k, popped, lastcnt;
  int          rr_pct = 100, pr_pct = 100, stall_from = -1, stall_len = 0, stall_cnt = 0;
  bit          rec_en = 0;
  int          sv [$];
  int          sl [$];
  bit          req_hold, pix_hold;
  logic [5:0]  hold_x, hold_y;
  logic [23:0] hold_d;
  logic        hold_l;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      k = 0; popped = 0; lastcnt = 0;
      sbq.delete();
      req_hold = 0; pix_hold = 0;
    end else begin
      logic [24:0] e;
      int ex, ey;
      if (req_hold) chk("req_stable", 32'({req_valid, req_x, req_y}), 32'({1'b1, hold_x, hold_y}));
      if (pix_hold) chk("pix_stable", 32'({pix_valid, pix_last, pix_data}), 32'({1'b1, hold_l, hold_d}));
      if (req_valid && req_ready) begin
        ex = k % W;
        ey = k / W;
        chk("req_xy", 32'({req_x, req_y}), 32'({6'(ex), 6'(ey)}));
        sbq.push_back({(k == N - 1), 8'(ex), 8'(ey), 8'(ex ^ ey)});
        k++;
      end
      if (pix_valid && pix_ready) begin
        if (sbq.size() == 0) begin
          chk("pix_unexpected", 32'(pix_data), 32'hFFFFFFFF);
        end else begin
          e = sbq.pop_front();
          chk("pix_data", 32'(pix_data), 32'(e[23:0]));
          chk("pix_last", 32'(pix_last), 32'(e[24]));
        end
        popped++;
        if (pix_last) lastcnt++;
      end
      chk("inflight_le_max", 32'(k - popped <= MO), 32'd1);
      req_hold = req_valid && !req_ready;
      hold_x   = req_x;
      hold_y   = req_y;
      pix_hold = pix_valid && !pix_ready;
      hold_d   = pix_data;
      hold_l   = pix_last;
      if (rec_en) begin
        if (sv.size() > 0 && sv[sv.size()-1] == int'(status)) sl[sl.size()-1]++;
        else begin
          sv.push_back(int'(status));
          sl.push_back(1);
        end
      end
    end
  end

  // Ready driver; during a stall it also checks that issue backs off at full occupancy.
  initial begin
    req_ready = 1'b0;
    pix_ready = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      req_ready = (int'($urandom_range(99)) < rr_pct);
      if (stall_from >= 0 && popped >= stall_from && stall_cnt < stall_len) begin
        pix_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == 20) begin
          chk("sat_req_valid", 32'(req_valid), 32'd0);
          chk("sat_pix_valid", 32'(pix_valid), 32'd1);
          chk("sat_inflight", 32'(k - popped), 32'(MO));
        end
      end else begin
        pix_ready = (int'($urandom_range(99)) < pr_pct);
      end
    end
  end

  typedef struct {
    int rr;
    int pr;
    int sfrom;
    int slen;
    int mid_start;
    int exp_pix;
    int exp_last;
    int exp_ff_len;
  } vec_t;

  vec_t tbl [5];
  int   ev [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF};

  task automatic set_knobs(input vec_t v);
    rr_pct = v.rr; pr_pct = v.pr; stall_from = v.sfrom; stall_len = v.slen; stall_cnt = 0;
    k = 0; popped = 0; lastcnt = 0;
    sbq.delete(); sv.delete(); sl.delete();
  endtask

  task automatic run_frame(input vec_t v);
    int cyc;
    set_knobs(v);
    @(posedge wb_clk_i); #1;
    start  = 1'b1;
    rec_en = 1;
    @(posedge wb_clk_i); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (busy && cyc < 30000) begin
      @(posedge wb_clk_i); #1;
      cyc++;
      start = (v.mid_start > 0 && cyc == v.mid_start);
    end
    start = 1'b0;
    chk("frame_timeout", 32'(cyc < 30000), 32'd1);
    @(negedge wb_clk_i); #1;
    rec_en = 0;
    chk("pix_count", 32'(popped), 32'(v.exp_pix));
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("last_count", 32'(lastcnt), 32'(v.exp_last));
    chk("status_runs", 32'(sv.size()), 32'd13);
    for (int i = 0; i < 12 && i < sv.size(); i++) chk("status_seq", 32'(sv[i]), 32'(ev[i]));
    if (sv.size() == 13) begin
      chk("status_end", 32'(sv[12]), 32'h00);
      chk("len_09", 32'(sl[9]), 32'd1);
      chk("len_0A", 32'(sl[10]), 32'd1);
      chk("len_FF", 32'(sl[11]), 32'(v.exp_ff_len));
    end
  endtask

  initial begin
    int cyc;
    tbl[0] = '{rr: 100, pr: 100, sfrom: -1, slen: 0,  mid_start: -1,  exp_pix: N, exp_last: 1, exp_ff_len: DH};
    tbl[1] = '{rr: 100, pr: 100, sfrom: 10, slen: 40, mid_start: -1,  exp_pix: N, exp_last: 1, exp_ff_len: DH};
    tbl[2] = '{rr: 50,  pr: 50,  sfrom: -1, slen: 0,  mid_start: -1,  exp_pix: N, exp_last: 1, exp_ff_len: DH};
    tbl[3] = '{rr: 100, pr: 100, sfrom: -1, slen: 0,  mid_start: 500, exp_pix: N, exp_last: 1, exp_ff_len: DH};
    tbl[4] = '{rr: 80,  pr: 30,  sfrom: -1, slen: 0,  mid_start: -1,  exp_pix: N, exp_last: 1, exp_ff_len: DH};

    wb_rst_i = 1'b1;
    start    = 1'b0;
    inj_v    = 1'b0;
    inj_rgb  = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_flags", 32'({req_valid, pix_valid, pix_last, busy, rsp_ready}), 32'd0);
    chk("rst_xy", 32'({req_x, req_y}), 32'd0);
    wb_rst_i = 1'b0;

    // Responses offered while idle must be refused.
    inj_rgb = 24'h123456;
    inj_v   = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    inj_v = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("idle_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("idle_rsp_ignored", 32'({pix_valid, busy, status}), 32'd0);

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Reset during the frame, then a clean frame.
    set_knobs(tbl[0]);
    @(posedge wb_clk_i); #1;
    start = 1'b1;
    @(posedge wb_clk_i); #1;
    start = 1'b0;
    cyc = 0;
    while (popped < 2000 && cyc < 10000) begin
      @(posedge wb_clk_i); #1;
      cyc++;
    end
    chk("mid_reset_reach", 32'(popped >= 2000), 32'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    chk("mid_reset_status", 32'(status), 32'h00);
    chk("mid_reset_flags", 32'({busy, pix_valid, req_valid}), 32'd0);
    repeat (5) @(posedge wb_clk_i);
    #1;
    chk("post_reset_idle", 32'({busy, pix_valid, status}), 32'd0);
    run_frame(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
